// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control and status bundle for the down-counting timer
interface down_counter_timer_if #(
  parameter int WIDTH = 8
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             decr;
  logic             periodic;
  logic [WIDTH-1:0] count_reg;
  logic             running;
  logic             done;
  logic             tc_pulse;

  modport master (
    output load, load_val, start, stop, decr, periodic,
    input  count_reg, running, done, tc_pulse
  );

  modport slave (
    input  load, load_val, start, stop, decr, periodic,
    output count_reg, running, done, tc_pulse
  );

endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counting timer with one-shot/periodic expiry
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  down_counter_timer_if.slave   tif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Priority per edge: load, then stop, then start, then decr.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (tif.load) begin
      count_d  = tif.load_val;
      reload_d = tif.load_val;
      if (tif.start && !tif.stop && (tif.load_val != ZERO)) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else if (tif.stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else begin
      if (tif.start && (state_q == IDLE) && (count_q != ZERO)) begin
        state_d = RUN;
      end
      if ((state_q == RUN) && tif.decr) begin
        if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else if (count_q == ONE) begin
          tc_d = 1'b1;
          if (tif.periodic) begin
            count_d = reload_q;
          end else begin
            count_d = ZERO;
            state_d = EXPIRED;
          end
        end else begin
          // Zero while running cannot be reached; park safely if it ever is.
          state_d = IDLE;
        end
      end
    end
  end

  assign tif.count_reg = count_q;
  assign tif.running   = (state_q == RUN);
  assign tif.done      = (state_q == EXPIRED);
  assign tif.tc_pulse  = tc_q;

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counting timer; the decrementing counterpart of the team's incrementing `counter` block.
- Counts a programmed value down to zero on qualified `decr` strobes.
- Flags expiry with a single-cycle terminal-count pulse and a sticky done level.
- Optionally auto-reloads for periodic operation.
- Sits beside `counter` in timing/event logic: `counter` measures elapsed events, this block schedules a future event.

Parameters:
- WIDTH, 8, bit width of the count and load value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe: capture `load_val` into the count and reload registers.
- load_val  input  WIDTH  value captured on `load`.
- start  input  1  begin/resume counting.
- stop  input  1  pause counting; the count is held.
- decr  input  1  decrement enable; sampled only in RUN.
- periodic  input  1  1 = auto-reload on expiry; 0 = one-shot.
- count_reg  output  WIDTH  current count (registered).
- running  output  1  high in RUN.
- done  output  1  high in EXPIRED (sticky).
- tc_pulse  output  1  registered one-cycle pulse on every expiry.

Behaviour:
- Reset (rstn=0, asynchronous): count_reg=0, reload register=0, state=IDLE, running=0, done=0, tc_pulse=0. Deassertion takes effect at the next clock edge.
- States: IDLE, RUN, EXPIRED. `running` = (state==RUN); `done` = (state==EXPIRED).
- Per-edge priority: load > stop > start > decr.
- load:
  - count_reg <= load_val and reload <= load_val.
  - If start=1, stop=0 and load_val!=0: next state RUN. Otherwise next state IDLE.
  - Valid from any state, including RUN and EXPIRED; clears `done`.
- stop (no load): RUN -> IDLE with count held. In IDLE or EXPIRED it has no effect.
- start (no load, no stop):
  - IDLE -> RUN if count_reg!=0.
  - IDLE with count_reg==0: stays IDLE.
  - EXPIRED: ignored; a new load is required.
- decr in RUN (no load, no stop):
  - count_reg>1: count_reg <= count_reg-1.
  - count_reg==1, periodic=0: count_reg <= 0, state <= EXPIRED, tc_pulse=1 on the following cycle.
  - count_reg==1, periodic=1: count_reg <= reload, state stays RUN, tc_pulse=1 on the following cycle. The period is exactly `reload` decr strobes.
  - decr outside RUN is ignored.
- tc_pulse is high for exactly one cycle per expiry. It is registered, so it is high in the same cycle count_reg first shows 0 (one-shot) or the reload value (periodic).
- Simultaneous load and expiring decr: load wins, no tc_pulse, and the new value is loaded.
- Count never underflows. count_reg==0 with state RUN is unreachable.
- `periodic` is sampled at the expiry edge only; changing it mid-count is legal.
- Reload value 1 in periodic mode gives a tc_pulse every decr cycle, with count_reg held at 1.
- Reset asserted mid-count clears everything immediately and suppresses any pending tc_pulse.
- Arithmetic is unsigned WIDTH-bit. Maximum load value is 2^WIDTH-1.

Test Plan:
1. Reset then idle: hold rstn=0 for 2 cycles, release -> count_reg=0, running=0, done=0, tc_pulse=0; start alone keeps IDLE.
2. One-shot: load=1, load_val=4, start=1 in the same cycle, then decr=1 continuously -> count_reg 4,3,2,1,0; tc_pulse high exactly on the cycle count_reg=0; done=1 and held; further decr/start leave count_reg=0.
3. Pause/resume: load 5 with start, 2 decr cycles (count 3), stop=1 for 3 cycles with decr=1 -> count_reg holds 3, running=0; start -> count resumes 2,1,0.
4. Periodic: periodic=1, load 3 with start, decr=1 for 9 cycles -> count_reg 3,2,1,3,2,1,3,2,1; tc_pulse on each cycle showing 3 after the first; done stays 0.
5. Collision: at count_reg=1 with decr=1, assert load=1, load_val=7, start=0 -> count_reg=7, state IDLE, no tc_pulse.
6. Async reset mid-count: at count_reg=2, drop rstn between clock edges -> all outputs 0 immediately without waiting for a clock edge; no tc_pulse after release.
